// File: rtl/cpud_target.sv
// cpud_target: CPU-data-port RAM target with a 2-entry request FIFO and in-order acks.
// Optional build macro CPUD_TARGET_WAITSTATE_EN: when defined, each ack waits WAIT_CYCLES
// extra cycles; when undefined, acks follow one cycle after acceptance.
// Ports:
//   clock            - sole clock, rising edge
//   reset            - asynchronous active-low reset
//   cpud_request     - one-cycle pulse offering a transaction
//   cpud_addr        - byte address (bits 1:0 ignored)
//   cpud_write       - 1 = write, 0 = read
//   cpud_byte_enable - write lane enables, bit i covers bits 8i+7:8i
//   cpud_wdata       - write data
//   cpud_rdata       - read data during a read ack, zero otherwise
//   cpud_ack         - one-cycle completion pulse for the oldest accepted transaction
//   range_error      - accompanies an ack whose address fell outside the RAM window
//   overflow         - sticky flag, a request hit a full FIFO and was dropped
module cpud_target #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpud_request,
  input  logic [31:0] cpud_addr,
  input  logic        cpud_write,
  input  logic [3:0]  cpud_byte_enable,
  input  logic [31:0] cpud_wdata,
  output logic [31:0] cpud_rdata,
  output logic        cpud_ack,
  output logic        range_error,
  output logic        overflow
);
`ifdef CPUD_TARGET_WAITSTATE_EN
  localparam logic [3:0] W = 4'(WAIT_CYCLES);
`else
  localparam logic [3:0] W = 4'(WAIT_CYCLES * 0);
`endif
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;
  typedef struct packed {
    logic [29:0] waddr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  txn_t                 slot_q [2];
  logic [31:0]          mem_q [2**ADDR_BITS];
  txn_t                 head;
  logic                 pop, push, wr_ptr, in_win, unused_addr_bits;
  logic [ADDR_BITS-1:0] widx;
  assign head             = slot_q[rd_ptr_q];
  assign pop              = state_q == S_RESPOND;
  // a full FIFO still accepts when the head retires in the same cycle
  assign push             = cpud_request && (count_q != 2'd2 || pop);
  // with two entries the free slot is the one being popped, i.e. rd_ptr
  assign wr_ptr           = rd_ptr_q ^ count_q[0];
  assign in_win           = head.waddr[29:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS+2];
  assign widx             = head.waddr[ADDR_BITS-1:0];
  assign cpud_ack         = pop;
  assign range_error      = pop && !in_win;
  assign cpud_rdata       = (pop && in_win && !head.write) ? mem_q[widx] : 32'h0;
  assign overflow         = overflow_q;
  assign unused_addr_bits = ^cpud_addr[1:0];
  always_comb begin
    count_d    = count_q + 2'(push) - 2'(pop);
    rd_ptr_d   = rd_ptr_q ^ pop;
    overflow_d = overflow_q | (cpud_request & ~push);
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? S_RESPOND : S_WAIT;
    end else if (count_d != 2'd0) begin
      // from IDLE or RESPOND with work pending; zero wait skips straight to RESPOND
      state_d = (W == 4'd0) ? S_RESPOND : S_WAIT;
      cnt_d   = W;
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) slot_q[wr_ptr] <= {cpud_addr[31:2], cpud_write, cpud_byte_enable, cpud_wdata};
  end
  always_ff @(posedge clock) begin
    if (pop && in_win && head.write)
      for (int i = 0; i < 4; i++)
        if (head.be[i]) mem_q[widx][8*i +: 8] <= head.wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_cpud_target.sv
// tb_cpud_target: randomized and directed bench for cpud_target against a transaction-level model.
module tb_cpud_target;
`ifdef CPUD_TARGET_WAITSTATE_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  localparam int          AB   = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic        clock = 0, reset = 0, cpud_request = 0, cpud_write = 0;
  logic [31:0] cpud_addr = 0, cpud_wdata = 0, cpud_rdata;
  logic [3:0]  cpud_byte_enable = 0;
  logic        cpud_ack, range_error, overflow;
  int          vectors = 0, errors = 0;
  typedef struct {logic [31:0] a; logic wr; logic [3:0] be; logic [31:0] wd; int at;} txn_t;
  typedef struct {logic ack; logic [31:0] rd; logic re; logic ovf; logic known;} exp_t;
  txn_t        q[$];
  logic [31:0] mem_m [int];
  int          cyc, last_ack;
  logic        ovf_m;

  cpud_target #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .cpud_request(cpud_request), .cpud_addr(cpud_addr),
    .cpud_write(cpud_write), .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata),
    .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack), .range_error(range_error), .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic logic in_win(input logic [31:0] a);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, BASE};
    return !d[32] && d < (33'd1 << (AB + 2));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_reset();
    q.delete();
    mem_m.delete();
    ovf_m    = 0;
    last_ack = -1000;
    cyc      = 0;
  endtask

  // one cycle: sample-time expectations for this cycle, then drive this cycle's request
  task automatic tick(input logic req, input logic [31:0] a, input logic wr, input logic [3:0] be,
                      input logic [31:0] wd, output exp_t e);
    txn_t        t;
    logic [31:0] w;
    int          i;
    @(negedge clock);
    e.ack = 0; e.rd = 0; e.re = 0; e.ovf = ovf_m; e.known = 1;
    if (q.size() > 0 && q[0].at == cyc) begin
      t     = q.pop_front();
      e.ack = 1;
      e.re  = !in_win(t.a);
      i     = word_of(t.a);
      if (!e.re && t.wr && (mem_m.exists(i) || t.be == 4'hF)) begin
        w = 32'h0;
        if (mem_m.exists(i)) w = mem_m[i];
        for (int b = 0; b < 4; b++) if (t.be[b]) w[8*b +: 8] = t.wd[8*b +: 8];
        mem_m[i] = w;
      end else if (!e.re && !t.wr) begin
        e.known = mem_m.exists(i);
        if (e.known) e.rd = mem_m[i];
      end
    end
    if (req) begin
      if (q.size() < 2) begin
        last_ack = (cyc + 1 + W > last_ack + 1 + W) ? cyc + 1 + W : last_ack + 1 + W;
        t.a = a; t.wr = wr; t.be = be; t.wd = wd; t.at = last_ack;
        q.push_back(t);
      end else begin
        ovf_m = 1;
      end
    end
    cpud_request = req; cpud_addr = a; cpud_write = wr; cpud_byte_enable = be; cpud_wdata = wd;
    cyc++;
  endtask

  task automatic test_reset();
    cpud_request = 0;
    @(posedge clock); #1;
    reset = 0;
    #1;
    vectors++;
    if ({cpud_ack, range_error, overflow} !== 3'b000 || cpud_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_async ack=%b re=%b ovf=%b rdata=%h, expected all zero", cpud_ack, range_error, overflow, cpud_rdata);
    end
    model_reset();
    repeat (2) @(negedge clock);
    vectors++;
    if ({cpud_ack, range_error, overflow} !== 3'b000 || cpud_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_held ack=%b re=%b ovf=%b rdata=%h, expected all zero", cpud_ack, range_error, overflow, cpud_rdata);
    end
    reset = 1;
  endtask

  task automatic test_basic_rw();
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      tick(k == 0 || k == 6, 32'h10, k == 0, 4'hF, 32'hDEADBEEF, e);
      vectors++;
      if (cpud_ack !== e.ack || range_error !== e.re || overflow !== e.ovf || (e.known && cpud_rdata !== e.rd)) begin
        errors++;
        $display("FAIL basic cyc=%0d ack=%b/%b re=%b/%b ovf=%b/%b rdata=%h/%h (got/expected)",
                 cyc - 1, cpud_ack, e.ack, range_error, e.re, overflow, e.ovf, cpud_rdata, e.rd);
      end
      if (k == 1 + W) begin
        vectors++;
        if (cpud_ack !== 1'b1) begin
          errors++;
          $display("FAIL basic_write_ack_latency ack=%b expected 1", cpud_ack);
        end
      end
      if (k == 7 + W) begin
        vectors++;
        if (cpud_ack !== 1'b1 || cpud_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL basic_readback ack=%b rdata=%h expected 1 deadbeef", cpud_ack, cpud_rdata);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    exp_t        e;
    logic [31:0] wdv [4] = '{32'h11223344, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h0};
    logic [3:0]  bev [4] = '{4'hF, 4'b0101, 4'h0, 4'h0};
    logic        wrv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int          j;
    for (int k = 0; k < 20; k++) begin
      j = (k / 4 < 4) ? k / 4 : 3;
      tick(k % 4 == 0 && k < 16, 32'h20, wrv[j], bev[j], wdv[j], e);
      vectors++;
      if (cpud_ack !== e.ack || range_error !== e.re || overflow !== e.ovf || (e.known && cpud_rdata !== e.rd)) begin
        errors++;
        $display("FAIL lanes cyc=%0d ack=%b/%b re=%b/%b ovf=%b/%b rdata=%h/%h (got/expected)",
                 cyc - 1, cpud_ack, e.ack, range_error, e.re, overflow, e.ovf, cpud_rdata, e.rd);
      end
      if (k == 13 + W) begin
        vectors++;
        if (cpud_ack !== 1'b1 || cpud_rdata !== 32'h11BB33DD) begin
          errors++;
          $display("FAIL lanes_merge ack=%b rdata=%h expected 1 11bb33dd", cpud_ack, cpud_rdata);
        end
      end
    end
  endtask

  task automatic test_range();
    exp_t        e;
    logic [31:0] av  [3] = '{32'h0001_0000, 32'h0001_0010, 32'h0000_0010};
    logic        wrv [3] = '{1'b0, 1'b1, 1'b0};
    int          j;
    for (int k = 0; k < 14; k++) begin
      j = (k / 4 < 3) ? k / 4 : 2;
      tick(k % 4 == 0 && k < 12, av[j], wrv[j], 4'hF, 32'h12345678, e);
      vectors++;
      if (cpud_ack !== e.ack || range_error !== e.re || overflow !== e.ovf || (e.known && cpud_rdata !== e.rd)) begin
        errors++;
        $display("FAIL range cyc=%0d ack=%b/%b re=%b/%b ovf=%b/%b rdata=%h/%h (got/expected)",
                 cyc - 1, cpud_ack, e.ack, range_error, e.re, overflow, e.ovf, cpud_rdata, e.rd);
      end
      if (k == 1 + W || k == 5 + W) begin
        vectors++;
        if (cpud_ack !== 1'b1 || range_error !== 1'b1 || cpud_rdata !== 32'h0) begin
          errors++;
          $display("FAIL range_flag k=%0d ack=%b re=%b rdata=%h expected 1 1 0", k, cpud_ack, range_error, cpud_rdata);
        end
      end
      if (k == 9 + W) begin
        vectors++;
        if (cpud_ack !== 1'b1 || range_error !== 1'b0 || cpud_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL range_no_alias ack=%b re=%b rdata=%h expected 1 0 deadbeef", cpud_ack, range_error, cpud_rdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] av [3] = '{32'h10, 32'h20, 32'h10};
    int          acks = 0;
    for (int k = 0; k < 14; k++) begin
      tick(k < 3, av[k < 3 ? k : 0], 1'b0, 4'h0, 32'h0, e);
      acks += int'(cpud_ack === 1'b1);
      vectors++;
      if (cpud_ack !== e.ack || range_error !== e.re || overflow !== e.ovf || (e.known && cpud_rdata !== e.rd)) begin
        errors++;
        $display("FAIL b2b cyc=%0d ack=%b/%b re=%b/%b ovf=%b/%b rdata=%h/%h (got/expected)",
                 cyc - 1, cpud_ack, e.ack, range_error, e.re, overflow, e.ovf, cpud_rdata, e.rd);
      end
    end
    vectors++;
    if (acks != ((W == 0) ? 3 : 2) || overflow !== (W != 0)) begin
      errors++;
      $display("FAIL b2b_count acks=%0d ovf=%b expected %0d %b", acks, overflow, (W == 0) ? 3 : 2, W != 0);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic        r, wr;
    logic [31:0] a;
    for (int k = 0; k < 360; k++) begin
      if (k < 32) begin
        r = (k % 4 == 0); wr = 1; a = 32'h40 + 32'(4 * (k / 4));
      end else if (k < 340) begin
        r  = $urandom_range(0, 1) == 1;
        wr = $urandom_range(0, 1) == 1;
        a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0001_0000)
                                        : 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      end else begin
        r = 0; wr = 0; a = 0;
      end
      tick(r, a, wr, (k < 32) ? 4'hF : 4'($urandom), $urandom, e);
      vectors++;
      if (cpud_ack !== e.ack || range_error !== e.re || overflow !== e.ovf || (e.known && cpud_rdata !== e.rd)) begin
        errors++;
        $display("FAIL random cyc=%0d ack=%b/%b re=%b/%b ovf=%b/%b rdata=%h/%h (got/expected)",
                 cyc - 1, cpud_ack, e.ack, range_error, e.re, overflow, e.ovf, cpud_rdata, e.rd);
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    tick(1'b1, 32'h30, 1'b1, 4'hF, 32'hCAFEF00D, e);
    @(posedge clock); #1;
    cpud_request = 0;
    reset = 0;
    #1;
    vectors++;
    if ({cpud_ack, range_error, overflow} !== 3'b000 || cpud_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midflight_reset ack=%b re=%b ovf=%b rdata=%h, expected all zero", cpud_ack, range_error, overflow, cpud_rdata);
    end
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1;
    for (int k = 0; k < 16; k++) begin
      tick(k == 8, 32'h10, 1'b0, 4'h0, 32'h0, e);
      vectors++;
      if (cpud_ack !== e.ack || range_error !== e.re || overflow !== e.ovf || (e.known && cpud_rdata !== e.rd)) begin
        errors++;
        $display("FAIL midflight cyc=%0d ack=%b/%b re=%b/%b ovf=%b/%b rdata=%h/%h (got/expected)",
                 cyc - 1, cpud_ack, e.ack, range_error, e.re, overflow, e.ovf, cpud_rdata, e.rd);
      end
      if (k == 9 + W) begin
        vectors++;
        if (cpud_ack !== 1'b1) begin
          errors++;
          $display("FAIL midflight_post_release_ack ack=%b expected 1", cpud_ack);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_range();
    test_back_to_back();
    test_reset();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
